// File: rtl/clk_period_meas_pkg.sv
// Shared definitions for the clock period measurement block: FSM state
// encoding, the minimum synchronizer depth and a helper that clamps a
// requested synchronizer depth to that minimum.
package clk_period_meas_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        COUNT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int SYNC_MIN = 2;

    // A synchronizer shallower than SYNC_MIN is not metastability-safe, so
    // any smaller request is raised to the minimum.
    function automatic int sync_depth(input int req);
        return (req < SYNC_MIN) ? SYNC_MIN : req;
    endfunction

endpackage

// File: rtl/clk_period_meas_sync_edge_det.sv
// Brings the asynchronous sig_in into the clk_in domain through a flop chain,
// keeps the previous synchronized value and flags a rising edge.
// With CLK_PERIOD_MEAS_HIGH_EN defined the synchronized level is also exported
// so the parent can count high cycles.
module sync_edge_det
    import clk_period_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_MIN
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
`ifdef CLK_PERIOD_MEAS_HIGH_EN
    output logic sync,
`endif
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;

    // Synchronizer shift chain plus previous-value flop, cleared by reset so a
    // high sig_in at reset release shows up as one rise.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_chain <= '0;
            prev       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
            prev       <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign rise = sync_chain[SYNC_STAGES-1] & ~prev;

`ifdef CLK_PERIOD_MEAS_HIGH_EN
    assign sync = sync_chain[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/clk_period_meas.sv
// Measures the period of an asynchronous periodic signal in clk_in cycles.
// A start pulse arms the block; the first synchronized rising edge opens the
// window, the next one closes it and the count is presented with valid until
// the consumer takes it with ready. Any wait longer than TIMEOUT cycles ends
// the measurement with timeout set.
// Optional feature macro: CLK_PERIOD_MEAS_HIGH_EN adds the high_time output,
// the number of cycles sig_in was high inside the measured period.
module clk_period_meas
    import clk_period_meas_pkg::*;
#(
    parameter int               CNT_W       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = {CNT_W{1'b1}}
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] period,
`ifdef CLK_PERIOD_MEAS_HIGH_EN
    output logic [CNT_W-1:0] high_time,
`endif
    output logic             timeout
);

    localparam int STAGES = sync_depth(SYNC_STAGES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             cnt_at_limit;

`ifdef CLK_PERIOD_MEAS_HIGH_EN
    logic             sync;
    logic [CNT_W-1:0] hcnt;
`endif

    sync_edge_det #(
        .SYNC_STAGES (STAGES)
    ) u_sync_edge_det (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
`ifdef CLK_PERIOD_MEAS_HIGH_EN
        .sync   (sync),
`endif
        .rise   (rise)
    );

    // TIMEOUT never exceeds the counter range, so cnt stops here before it
    // could wrap.
    assign cnt_at_limit = (cnt == TIMEOUT);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a rise wins over the limit when both occur together.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (rise) begin
                    state_nxt = COUNT;
                end else if (cnt_at_limit) begin
                    state_nxt = DONE;
                end
            end
            COUNT: begin
                if (rise || cnt_at_limit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE);
    end

    // Cycle counter and result registers; results only change on the way
    // into DONE, so they stay frozen while valid is high.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt     <= '0;
            period  <= '0;
            timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        timeout <= 1'b0;
                    end
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt <= CNT_W'(1);
                    end else if (cnt_at_limit) begin
                        period  <= '0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                COUNT: begin
                    if (rise) begin
                        period  <= cnt;
                        timeout <= 1'b0;
                    end else if (cnt_at_limit) begin
                        period  <= TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CLK_PERIOD_MEAS_HIGH_EN
    // High-time counter: the opening rise cycle is itself a high cycle, then
    // every further high cycle inside the window adds one.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            unique case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        hcnt <= CNT_W'(1);
                    end else if (cnt_at_limit) begin
                        high_time <= '0;
                    end
                end
                COUNT: begin
                    if (rise) begin
                        high_time <= hcnt;
                    end else if (cnt_at_limit) begin
                        high_time <= '0;
                    end else if (sync) begin
                        hcnt <= hcnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_clk_period_meas.sv
// Self-checking bench for clk_period_meas. The sig_in waveform is recorded per
// cycle; expected results come from locating rising edges in that record and
// applying the measurement rules with plain arithmetic.
module tb_clk_period_meas;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TO          = 100;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int HMAX        = 16384;

    typedef struct {
        int   n;
        int   exp_p;
        logic exp_to;
        int   exp_h;
    } vec_t;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             sig_in = 1'b0;
    logic             start  = 1'b0;
    logic             ready  = 1'b1;
    logic             busy;
    logic             valid;
    logic             timeout;
    logic [CNT_W-1:0] period;
`ifdef CLK_PERIOD_MEAS_HIGH_EN
    logic [CNT_W-1:0] high_time;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   hist[HMAX];
    int   mode  = 0;
    bit   lvl   = 1'b0;
    int   div_n = 8;
    int   phase = 0;
    int   seg_left = 0;
    vec_t vecs[7];

    clk_period_meas #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (CNT_W'(TO))
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .sig_in    (sig_in),
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .valid     (valid),
        .period    (period),
`ifdef CLK_PERIOD_MEAS_HIGH_EN
        .high_time (high_time),
`endif
        .timeout   (timeout)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Advance one clock; drive the next sig_in sample 1 ns after the edge.
    task automatic step();
        @(posedge clk_in);
        cyc++;
        #1;
        case (mode)
            0: sig_in = lvl;
            1: begin
                phase  = (phase + 1) % div_n;
                sig_in = (phase < div_n / 2);
            end
            default: begin
                if (seg_left == 0) begin
                    lvl      = ~lvl;
                    seg_left = int'($urandom_range(1, 12));
                end
                seg_left--;
                sig_in = lvl;
            end
        endcase
        if (cyc < HMAX) hist[cyc] = sig_in;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int find_rise(input int from);
        for (int j = (from < 1) ? 1 : from; j <= cyc && j < HMAX; j++)
            if (hist[j] && !hist[j-1]) return j;
        return -1;
    endfunction

    // One full measurement: start pulse, wait for valid, compare with the
    // reference, optionally hold ready low for 'hold' cycles, then handshake.
    task automatic run_meas(input string name, input int idle, input int hold,
                            output int k0, output int tv,
                            output logic [31:0] got_p, output logic got_to,
                            output logic [31:0] got_h);
        int               j1, j2, exp_tv, exp_p, exp_h;
        logic             exp_to;
        logic             stable;
        logic [CNT_W-1:0] p0;
        ready = (hold == 0);
        repeat (idle) step();
        start = 1'b1;
        k0 = cyc;
        step();
        start = 1'b0;
        tv = -1;
        for (int i = 0; i < 400; i++) begin
            if (valid === 1'b1) begin
                tv = cyc;
                break;
            end
            step();
        end
        got_p  = 32'(period);
        got_to = timeout;
`ifdef CLK_PERIOD_MEAS_HIGH_EN
        got_h = 32'(high_time);
`else
        got_h = '0;
`endif
        // Start is taken at edge k0+1; a rise found at sample j acts at edge j+LAT.
        j1    = find_rise(k0 - 1);
        exp_h = 0;
        if (j1 < 0 || j1 + LAT > k0 + TO + 2) begin
            exp_tv = k0 + TO + 2;
            exp_p  = 0;
            exp_to = 1'b1;
        end else begin
            j2 = find_rise(j1 + 1);
            if (j2 < 0 || j2 - j1 > TO) begin
                exp_tv = j1 + LAT + TO;
                exp_p  = TO;
                exp_to = 1'b1;
            end else begin
                exp_tv = j2 + LAT;
                exp_p  = j2 - j1;
                exp_to = 1'b0;
                for (int j = j1; j < j2; j++) exp_h += int'(hist[j]);
            end
        end
        check({name, " latency"}, tv, exp_tv);
        check({name, " period"}, got_p, exp_p);
        check({name, " timeout"}, {31'd0, got_to}, {31'd0, exp_to});
        check({name, " busy_in_done"}, {31'd0, busy}, 32'd1);
`ifdef CLK_PERIOD_MEAS_HIGH_EN
        check({name, " high_time"}, got_h, exp_h);
`endif
        if (hold > 0) begin
            stable = 1'b1;
            p0     = period;
            for (int i = 0; i < hold; i++) begin
                if (i == hold / 2) start = 1'b1;
                step();
                start = 1'b0;
                if (valid !== 1'b1 || busy !== 1'b1 || period !== p0 || timeout !== got_to)
                    stable = 1'b0;
            end
            check({name, " held_stable"}, {31'd0, stable}, 32'd1);
            ready = 1'b1;
            start = 1'b1;
        end
        step();
        start = 1'b0;
        check({name, " valid_after_ack"}, {31'd0, valid}, 32'd0);
        check({name, " busy_after_ack"}, {31'd0, busy}, 32'd0);
        if (hold > 0) begin
            repeat (10) step();
            check({name, " no_restart"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int          k0, tv, j1;
        logic [31:0] gp, gh;
        logic        gt;

        vecs[0] = '{n: 8,   exp_p: 8,   exp_to: 1'b0, exp_h: 4};
        vecs[1] = '{n: 2,   exp_p: 2,   exp_to: 1'b0, exp_h: 1};
        vecs[2] = '{n: 3,   exp_p: 3,   exp_to: 1'b0, exp_h: 1};
        vecs[3] = '{n: 5,   exp_p: 5,   exp_to: 1'b0, exp_h: 2};
        vecs[4] = '{n: 16,  exp_p: 16,  exp_to: 1'b0, exp_h: 8};
        vecs[5] = '{n: 100, exp_p: 100, exp_to: 1'b0, exp_h: 50};
        vecs[6] = '{n: 101, exp_p: 100, exp_to: 1'b1, exp_h: 0};

        // Reset with sig_in high: the spurious rise after release must be ignored.
        mode = 0;
        lvl  = 1'b1;
        rst  = 1'b1;
        repeat (3) step();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset period", 32'(period), 32'd0);
        check("reset timeout", {31'd0, timeout}, 32'd0);
`ifdef CLK_PERIOD_MEAS_HIGH_EN
        check("reset high_time", 32'(high_time), 32'd0);
`endif
        rst = 1'b0;
        repeat (6) step();
        check("idle after spurious rise", {31'd0, busy}, 32'd0);

        // Divider table, including the exact-limit and one-past-limit periods.
        for (int i = 0; i < 7; i++) begin
            mode  = 1;
            div_n = vecs[i].n;
            phase = 0;
            run_meas($sformatf("div%0d", vecs[i].n), 4, 0, k0, tv, gp, gt, gh);
            check($sformatf("div%0d table_period", vecs[i].n), gp, vecs[i].exp_p);
            check($sformatf("div%0d table_timeout", vecs[i].n), {31'd0, gt}, {31'd0, vecs[i].exp_to});
`ifdef CLK_PERIOD_MEAS_HIGH_EN
            check($sformatf("div%0d table_high", vecs[i].n), gh, vecs[i].exp_h);
`endif
        end

        // Back-to-back measurements of a divide-by-2 signal.
        mode  = 1;
        div_n = 2;
        phase = 0;
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            run_meas($sformatf("b2b%0d", i), 0, 0, k0, tv, gp, gt, gh);
            check($sformatf("b2b%0d is_2", i), gp, 32'd2);
        end

        // sig_in stuck low: timeout while waiting for the first edge.
        mode = 0;
        lvl  = 1'b0;
        run_meas("wait_timeout", 4, 0, k0, tv, gp, gt, gh);
        check("wait_timeout cycles_from_start", tv - (k0 + 1), 32'd101);
        check("wait_timeout flag", {31'd0, gt}, 32'd1);
        check("wait_timeout period_zero", gp, 32'd0);

        // Consumer stalls 20 cycles in DONE while start is pulsed.
        mode  = 1;
        div_n = 8;
        phase = 0;
        run_meas("stall", 4, 20, k0, tv, gp, gt, gh);
        check("stall period", gp, 32'd8);

        // Reset in the middle of COUNT aborts; the next measurement still works.
        repeat (4) step();
        start = 1'b1;
        k0 = cyc;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            j1 = find_rise(k0 - 1);
            if (j1 >= 0 && cyc >= j1 + LAT + 3) break;
            step();
        end
        rst = 1'b1;
        step();
        check("midcount_rst busy", {31'd0, busy}, 32'd0);
        check("midcount_rst valid", {31'd0, valid}, 32'd0);
        check("midcount_rst period", 32'(period), 32'd0);
        rst = 1'b0;
        run_meas("after_rst", 4, 0, k0, tv, gp, gt, gh);
        check("after_rst is_8", gp, 32'd8);

        // Random high/low segment lengths, compared with the reference.
        mode     = 2;
        lvl      = 1'b0;
        seg_left = 0;
        for (int i = 0; i < 20; i++)
            run_meas($sformatf("rand%0d", i), int'($urandom_range(0, 5)), 0, k0, tv, gp, gt, gh);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
